// File: rtl/key_scan_if.sv
// Button-pad bus between the raw key lines and the key_scan event outputs.
// master is the scanner side, slave the consumer/pad side.
interface key_scan_if;
  logic [4:0] key;
  logic       key_valid;
  logic [2:0] key_code;
  logic       key_hold;

  modport master (input key, output key_valid, output key_code, output key_hold);
  modport slave  (output key, input key_valid, input key_code, input key_hold);
endinterface

// File: rtl/key_scan.sv
// Five-button pad front-end: synchronise, debounce, accept single-key presses only,
// emit one-cycle coded events and hold-to-repeat for the keys in REPEAT_MASK.
module key_scan #(
  parameter int unsigned DEBOUNCE_CYC = 2_000_000,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter logic [4:0]  REPEAT_MASK  = 5'b10010
) (
  input  logic       clk,
  input  logic       rst,
  key_scan_if.master pad
);

  localparam int unsigned CntW = 27;
  localparam int unsigned KeyW = 5;
  localparam int unsigned CodeW = 3;
  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [CntW-1:0] DlyLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RteLast = CntW'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_HELD, S_REPEAT, S_RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [KeyW-1:0]  sync_q, key_s_q;
  logic [KeyW-1:0]  cand_q, cand_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [CodeW-1:0] code_q, code_d;
  logic             hold_q, hold_d;

  function automatic logic [CodeW-1:0] encode(input logic [KeyW-1:0] v);
    logic [CodeW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(KeyW); i++) begin
      if (v[i]) c = CodeW'(i + 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      key_s_q <= '0;
      state_q <= S_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      sync_q  <= pad.key;
      key_s_q <= sync_q;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      hold_q  <= hold_d;
    end
  end

  // Next state, shared counter and event generation
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    code_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if ($onehot(key_s_q)) begin
          cand_d  = key_s_q;
          cnt_d   = '0;
          state_d = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (key_s_q != cand_q) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == DebLast) begin
          valid_d = 1'b1;
          code_d  = encode(cand_q);
          cnt_d   = '0;
          state_d = S_HELD;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_HELD: begin
        if (key_s_q != cand_q) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if ((cand_q & REPEAT_MASK) != '0) begin
          if (cnt_q == DlyLast) begin
            valid_d = 1'b1;
            code_d  = encode(cand_q);
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      S_REPEAT: begin
        if (key_s_q != cand_q) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (cnt_q == RteLast) begin
          valid_d = 1'b1;
          code_d  = encode(cand_q);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_RELEASE: begin
        // Any key activity restarts the all-released window
        if (key_s_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    hold_d = (state_d == S_HELD) || (state_d == S_REPEAT);
  end

  assign pad.key_valid = valid_q;
  assign pad.key_code  = code_q;
  assign pad.key_hold  = hold_q;

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: vector table, hand-written corner sequences and random
// stimulus, all checked every cycle against a timestamp-based reference model.
module tb_key_scan;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam logic [4:0] RMASK = 5'b10010;

  localparam int M_IDLE = 0, M_DEB = 1, M_HELD = 2, M_REP = 3, M_REL = 4;

  logic clk = 1'b0;
  logic rst;
  key_scan_if kif ();

  key_scan #(
    .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(RMASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pad(kif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: raw-key delay line plus a phase and the cycle it began
  logic [4:0] m_s1, m_s2, m_cand;
  int m_mode, m_t0;

  int n_ev;
  int last_code;
  int ev_q[$];

  typedef struct {
    logic [4:0] key;
    int hold;
    int n_ev;
    int code;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int code_of(input logic [4:0] v);
    return $clog2(int'(v)) + 1;
  endfunction

  task automatic tick();
    logic [4:0] ks;
    bit ev;
    @(posedge clk);
    cyc++;
    ev = 1'b0;
    ks = m_s2;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_cand = '0; m_mode = M_IDLE; m_t0 = cyc;
    end else begin
      m_s2 = m_s1;
      m_s1 = kif.key;
      case (m_mode)
        M_IDLE: if ($countones(ks) == 1) begin
          m_cand = ks; m_t0 = cyc; m_mode = M_DEB;
        end
        M_DEB: if (ks != m_cand) m_mode = M_IDLE;
               else if (cyc - m_t0 == DEB) begin ev = 1'b1; m_mode = M_HELD; m_t0 = cyc; end
        M_HELD: if (ks != m_cand) begin m_mode = M_REL; m_t0 = cyc; end
                else if ((m_cand & RMASK) == '0) m_t0 = m_t0;
                else if (cyc - m_t0 == RD) begin ev = 1'b1; m_mode = M_REP; m_t0 = cyc; end
        M_REP: if (ks != m_cand) begin m_mode = M_REL; m_t0 = cyc; end
               else if (cyc - m_t0 == RR) begin ev = 1'b1; m_t0 = cyc; end
        default: if (ks != '0) m_t0 = cyc;
                 else if (cyc - m_t0 == DEB) m_mode = M_IDLE;
      endcase
    end
    #1;
    check("key_valid", int'(kif.key_valid), int'(ev));
    check("key_code", int'(kif.key_code), ev ? code_of(m_cand) : 0);
    check("key_hold", int'(kif.key_hold), int'(m_mode == M_HELD || m_mode == M_REP));
    if (kif.key_valid) begin
      n_ev++;
      last_code = int'(kif.key_code);
      ev_q.push_back(cyc);
    end
  endtask

  initial begin
    int n0, fall, rel_edge;
    logic [4:0] rk;
    vecs[0] = '{5'b00001,  8, 1, 1};
    vecs[1] = '{5'b10000, 30, 7, 5};
    vecs[2] = '{5'b00100, 40, 1, 3};
    vecs[3] = '{5'b00011, 20, 0, 0};
    vecs[4] = '{5'b00010,  5, 1, 2};
    vecs[5] = '{5'b00010,  4, 0, 0};
    vecs[6] = '{5'b01000,  3, 0, 0};
    vecs[7] = '{5'b00010, 15, 2, 2};
    vecs[8] = '{5'b00010, 14, 1, 2};
    vecs[9] = '{5'b10000, 18, 3, 5};

    rst = 1'b1;
    kif.key = '0;
    tick();
    tick();
    check("reset_valid", int'(kif.key_valid), 0);
    check("reset_code", int'(kif.key_code), 0);
    check("reset_hold", int'(kif.key_hold), 0);
    rst = 1'b0;
    repeat (3) tick();

    for (int v = 0; v < 10; v++) begin
      n_ev = 0;
      last_code = 0;
      kif.key = vecs[v].key;
      repeat (vecs[v].hold) tick();
      kif.key = '0;
      repeat (12) tick();
      check($sformatf("vec%0d_events", v), n_ev, vecs[v].n_ev);
      if (vecs[v].n_ev > 0) check($sformatf("vec%0d_code", v), last_code, vecs[v].code);
    end

    // Clean press: event at N+6, hold falls 2 edges after raw release
    n_ev = 0; ev_q.delete();
    kif.key = 5'b00001;
    n0 = cyc + 1;
    repeat (8) tick();
    kif.key = '0;
    rel_edge = cyc + 1;
    fall = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!kif.key_hold && fall < 0) fall = cyc;
    end
    check("clean_events", n_ev, 1);
    check("clean_at_N6", (ev_q.size() > 0) ? ev_q[0] - n0 : -1, 6);
    check("clean_hold_fall", fall - rel_edge, 2);

    // Bounce every 2 cycles: no event, and IDLE afterwards
    n_ev = 0;
    for (int i = 0; i < 20; i++) begin
      kif.key = ((i / 2) % 2 == 0) ? 5'b01000 : 5'b00000;
      tick();
    end
    kif.key = '0;
    repeat (10) tick();
    check("bounce_events", n_ev, 0);
    check("bounce_hold", int'(kif.key_hold), 0);

    // Multi-key: chord, then second key added while held, then full release
    n_ev = 0;
    kif.key = 5'b00011;
    repeat (20) tick();
    kif.key = '0;
    repeat (10) tick();
    check("chord_events", n_ev, 0);
    kif.key = 5'b00010;
    for (int i = 0; i < 20 && n_ev < 1; i++) tick();
    check("mk_first_event", n_ev, 1);
    kif.key = 5'b00011;
    repeat (14) tick();
    check("mk_no_more_events", n_ev, 1);
    check("mk_hold_dropped", int'(kif.key_hold), 0);
    kif.key = '0;
    repeat (6) tick();
    ev_q.delete(); n_ev = 0;
    kif.key = 5'b10000;
    n0 = cyc + 1;
    repeat (8) tick();
    check("mk_idle_again", (ev_q.size() > 0) ? ev_q[0] - n0 : -1, 6);
    kif.key = '0;
    repeat (12) tick();

    // Reset while repeating: press discarded, fresh first event and full delay
    n_ev = 0;
    kif.key = 5'b00010;
    for (int i = 0; i < 40 && n_ev < 2; i++) tick();
    check("rst_reached_repeat", n_ev, 2);
    rst = 1'b1;
    tick();
    check("rst_valid", int'(kif.key_valid), 0);
    check("rst_code", int'(kif.key_code), 0);
    check("rst_hold", int'(kif.key_hold), 0);
    rst = 1'b0;
    ev_q.delete(); n_ev = 0;
    n0 = cyc + 1;
    repeat (20) tick();
    check("rst_first_at_N6", (ev_q.size() > 0) ? ev_q[0] - n0 : -1, 6);
    check("rst_first_delay", (ev_q.size() > 1) ? ev_q[1] - ev_q[0] : -1, RD);
    check("rst_code_after", last_code, 2);
    kif.key = '0;
    repeat (12) tick();

    // Random segments with occasional resets
    for (int s = 0; s < 80; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rk = '0;
        3, 4:    rk = 5'($urandom_range(0, 31));
        default: rk = 5'(1 << $urandom_range(0, 4));
      endcase
      kif.key = rk;
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 30)) tick();
    end
    kif.key = '0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
